// File: rtl/multi_com_tracker.sv
// rtl/multi_com_tracker.sv - multi-channel centre-of-mass tracker with shared sequential divider
module multi_com_tracker #(
  parameter int CHANNELS  = 2,
  parameter int H_WIDTH   = 11,
  parameter int V_WIDTH   = 10,
  parameter int MIN_COUNT = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [H_WIDTH-1:0]            x_in,
  input  logic [V_WIDTH-1:0]            y_in,
  input  logic                          valid_in,
  input  logic [CHANNELS-1:0]           mask_in,
  input  logic                          tabulate_in,
  output logic [CHANNELS*H_WIDTH-1:0]   x_com_out,
  output logic [CHANNELS*V_WIDTH-1:0]   y_com_out,
  output logic [CHANNELS-1:0]           found_out,
  output logic                          valid_out,
  output logic                          busy_out,
  output logic                          dropped_out
);
  localparam int CW   = H_WIDTH + V_WIDTH;
  localparam int DW_X = CW + H_WIDTH;
  localparam int DW_Y = CW + V_WIDTH;
  localparam int DWM  = (DW_X > DW_Y) ? DW_X : DW_Y;
  localparam int QW   = (H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH;
  localparam int DCW  = $clog2(DWM);
  localparam int KW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {ACCUM, SETUP, DIV_X, DIV_Y, NEXT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [KW-1:0]              k_q, k_d;
  logic [CW-1:0]              cnt_q [CHANNELS], cnt_d [CHANNELS];
  logic [DW_X-1:0]            sx_q [CHANNELS], sx_d [CHANNELS];
  logic [DW_Y-1:0]            sy_q [CHANNELS], sy_d [CHANNELS];
  logic [CW-1:0]              hcnt_q [CHANNELS], hcnt_d [CHANNELS];
  logic [DW_X-1:0]            hsx_q [CHANNELS], hsx_d [CHANNELS];
  logic [DW_Y-1:0]            hsy_q [CHANNELS], hsy_d [CHANNELS];
  logic [H_WIDTH-1:0]         resx_q [CHANNELS], resx_d [CHANNELS];
  logic [V_WIDTH-1:0]         resy_q [CHANNELS], resy_d [CHANNELS];
  logic [CHANNELS-1:0]        resf_q, resf_d;
  logic [DWM-1:0]             dvd_q, dvd_d;
  logic [CW-1:0]              rem_q, rem_d, dvs_q, dvs_d;
  logic [QW-1:0]              quo_q, quo_d;
  logic [DCW-1:0]             dcnt_q, dcnt_d;
  logic [CHANNELS*H_WIDTH-1:0] xcom_q, xcom_d;
  logic [CHANNELS*V_WIDTH-1:0] ycom_q, ycom_d;
  logic [CHANNELS-1:0]        found_q, found_d;
  logic                       valid_q, valid_d, dropped_q, dropped_d;

  logic [CW:0]                trial, dvs_ext, diff;
  logic                       qbit;
  logic [CW-1:0]              rem_step;
  logic [QW-1:0]              quo_step;
  logic                       busy;

  // Result cycle counts as busy so a strobe there is reported as dropped.
  assign busy = (state_q != ACCUM) || valid_q;

  // Live accumulators: any strobe clears them, a same-cycle pixel lands in the new frame.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = tabulate_in ? '0 : cnt_q[i];
      sx_d[i]  = tabulate_in ? '0 : sx_q[i];
      sy_d[i]  = tabulate_in ? '0 : sy_q[i];
      if (valid_in && mask_in[i]) begin
        cnt_d[i] = cnt_d[i] + CW'(1);
        sx_d[i]  = sx_d[i] + DW_X'(x_in);
        sy_d[i]  = sy_d[i] + DW_Y'(y_in);
      end
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {rem_q, dvd_q[DWM-1]};
    dvs_ext  = {1'b0, dvs_q};
    diff     = trial - dvs_ext;
    qbit     = (trial >= dvs_ext);
    rem_step = qbit ? CW'(diff) : CW'(trial);
    quo_step = (quo_q << 1) | QW'(qbit);
  end

  // Control FSM: snapshot, walk channels through the shared divider, publish together.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    hcnt_d    = hcnt_q;
    hsx_d     = hsx_q;
    hsy_d     = hsy_q;
    resx_d    = resx_q;
    resy_d    = resy_q;
    resf_d    = resf_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    dcnt_d    = dcnt_q;
    xcom_d    = xcom_q;
    ycom_d    = ycom_q;
    found_d   = found_q;
    valid_d   = 1'b0;
    dropped_d = tabulate_in && busy;
    case (state_q)
      ACCUM: begin
        if (tabulate_in && !busy) begin
          hcnt_d  = cnt_q;
          hsx_d   = sx_q;
          hsy_d   = sy_q;
          k_d     = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (hcnt_q[k_q] < CW'(MIN_COUNT)) begin
          resf_d[k_q] = 1'b0;
          state_d     = NEXT;
        end else begin
          resf_d[k_q] = 1'b1;
          dvs_d       = hcnt_q[k_q];
          dvd_d       = DWM'(hsx_q[k_q]) << (DWM - DW_X);
          rem_d       = '0;
          quo_d       = '0;
          dcnt_d      = DCW'(DW_X - 1);
          state_d     = DIV_X;
        end
      end
      DIV_X: begin
        dvd_d  = dvd_q << 1;
        rem_d  = rem_step;
        quo_d  = quo_step;
        dcnt_d = dcnt_q - DCW'(1);
        if (dcnt_q == '0) begin
          resx_d[k_q] = quo_step[H_WIDTH-1:0];
          dvd_d       = DWM'(hsy_q[k_q]) << (DWM - DW_Y);
          rem_d       = '0;
          quo_d       = '0;
          dcnt_d      = DCW'(DW_Y - 1);
          state_d     = DIV_Y;
        end
      end
      DIV_Y: begin
        dvd_d  = dvd_q << 1;
        rem_d  = rem_step;
        quo_d  = quo_step;
        dcnt_d = dcnt_q - DCW'(1);
        if (dcnt_q == '0) begin
          resy_d[k_q] = quo_step[V_WIDTH-1:0];
          state_d     = NEXT;
        end
      end
      NEXT: begin
        if (k_q == KW'(CHANNELS - 1)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = SETUP;
        end
      end
      DONE: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (resf_q[i]) begin
            xcom_d[i*H_WIDTH +: H_WIDTH] = resx_q[i];
            ycom_d[i*V_WIDTH +: V_WIDTH] = resy_q[i];
          end
        end
        found_d = resf_q;
        valid_d = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ACCUM;
      k_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        sx_q[i]   <= '0;
        sy_q[i]   <= '0;
        hcnt_q[i] <= '0;
        hsx_q[i]  <= '0;
        hsy_q[i]  <= '0;
        resx_q[i] <= '0;
        resy_q[i] <= '0;
      end
      resf_q    <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      dcnt_q    <= '0;
      xcom_q    <= '0;
      ycom_q    <= '0;
      found_q   <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      hcnt_q    <= hcnt_d;
      hsx_q     <= hsx_d;
      hsy_q     <= hsy_d;
      resx_q    <= resx_d;
      resy_q    <= resy_d;
      resf_q    <= resf_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      dcnt_q    <= dcnt_d;
      xcom_q    <= xcom_d;
      ycom_q    <= ycom_d;
      found_q   <= found_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign x_com_out   = xcom_q;
  assign y_com_out   = ycom_q;
  assign found_out   = found_q;
  assign valid_out   = valid_q;
  assign busy_out    = busy;
  assign dropped_out = dropped_q;
endmodule
